udp_frame_rx: RTL and testbench

// Receive-side counterpart of the UDP frame transmitter. Takes the MII byte stream (after nibble assembly),

---
 rtl/udp_frame_rx_if.sv | 26 ++
 rtl/udp_frame_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_udp_frame_rx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_frame_rx_if.sv
// Byte-stream receive bus and UDP payload/status bus of udp_frame_rx.
// master drives the receive side, slave is the receiver.
interface udp_frame_rx_if;
    logic        rx_dv;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_sof;
    logic        pay_eof;
    logic [15:0] pay_len;
    logic        frame_ok;
    logic        frame_err;

    modport master (
        output rx_dv, rx_en, rx_data,
        input  pay_data, pay_valid, pay_sof, pay_eof,
        input  pay_len, frame_ok, frame_err
    );

    modport slave (
        input  rx_dv, rx_en, rx_data,
        output pay_data, pay_valid, pay_sof, pay_eof,
        output pay_len, frame_ok, frame_err
    );
endinterface

// File: rtl/udp_frame_rx.sv
// UDP frame receiver: preamble/SFD strip, Eth/IPv4/UDP header filter,
// payload streaming and CRC-32 check of the FCS at end of frame.
module udp_frame_rx #(
    parameter logic [47:0] MAC_ADDR     = 48'hd03745f66d9c,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [31:0] IP_ADDR      = 32'hc0a80102,
    parameter logic [15:0] UDP_PORT     = 16'h4e21,
    parameter int          MAX_PAYLOAD  = 1472
) (
    input logic             clk,
    input logic             rst_n,
    udp_frame_rx_if.slave   bus
);

    localparam logic [2:0] S_DROP = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_PRE  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;

    localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD + 8);
    localparam logic [31:0] CRC_GOOD  = 32'hdebb20e3;

    logic [2:0]  state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        uni_ok_q, uni_ok_d;
    logic        bc_ok_q, bc_ok_d;
    logic [15:0] len_q, len_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic [7:0]  pay_data_q, pay_data_d;
    logic        pay_valid_q, pay_valid_d;
    logic        pay_sof_q, pay_sof_d;
    logic        pay_eof_q, pay_eof_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;

    logic        byte_v;
    logic [10:0] cnt_inc;
    logic [31:0] crc_nxt;
    logic [7:0]  mac_b;
    logic [1:0]  ip_sel;
    logic [7:0]  ip_b;
    logic [15:0] len_w;
    logic        pay_last;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        end
        return r;
    endfunction

    assign byte_v   = bus.rx_dv && bus.rx_en;
    assign cnt_inc  = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
    assign crc_nxt  = crc_byte(crc_q, bus.rx_data);
    assign mac_b    = 8'(MAC_ADDR >> {3'd5 - cnt_q[2:0], 3'b000});
    assign ip_sel   = cnt_q[1:0] - 2'd2;
    assign ip_b     = 8'(IP_ADDR >> {2'd3 - ip_sel, 3'b000});
    assign len_w    = {len_q[15:8], bus.rx_data};
    assign pay_last = (cnt_q == 11'd41 + pay_len_q[10:0]);

    // Frame parser: state, byte counter, CRC and header filtering.
    always_comb begin
        logic hdr_bad;
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        uni_ok_d    = uni_ok_q;
        bc_ok_d     = bc_ok_q;
        len_d       = len_q;
        pay_len_d   = pay_len_q;
        pay_data_d  = pay_data_q;
        pay_valid_d = 1'b0;
        pay_sof_d   = 1'b0;
        pay_eof_d   = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        hdr_bad     = 1'b0;

        case (state_q)
            S_DROP: begin
                if (!bus.rx_dv) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (byte_v) begin
                    if (bus.rx_data == 8'h55) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!bus.rx_dv) begin
                    state_d = S_IDLE;
                end else if (byte_v) begin
                    if (bus.rx_data == 8'h55) begin
                        if (pre_cnt_q == 3'd7) state_d = S_DROP;
                        else pre_cnt_d = pre_cnt_q + 3'd1;
                    end else if (bus.rx_data == 8'hd5) begin
                        state_d = S_HDR;
                        cnt_d   = 11'd0;
                        crc_d   = 32'hffffffff;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_HDR: begin
                if (!bus.rx_dv) begin
                    state_d = S_IDLE;
                end else if (byte_v) begin
                    cnt_d = cnt_inc;
                    crc_d = crc_nxt;
                    unique case (1'b1)
                        (cnt_q <= 11'd5): begin
                            uni_ok_d = (cnt_q == 11'd0 || uni_ok_q)
                                       && (bus.rx_data == mac_b);
                            bc_ok_d  = (cnt_q == 11'd0 || bc_ok_q)
                                       && (bus.rx_data == 8'hff);
                            if (cnt_q == 11'd5) begin
                                hdr_bad = !(uni_ok_d
                                            || (ACCEPT_BCAST && bc_ok_d));
                            end
                        end
                        (cnt_q == 11'd12): hdr_bad = bus.rx_data != 8'h08;
                        (cnt_q == 11'd13): hdr_bad = bus.rx_data != 8'h00;
                        (cnt_q == 11'd14): hdr_bad = bus.rx_data != 8'h45;
                        (cnt_q == 11'd23): hdr_bad = bus.rx_data != 8'h11;
                        (cnt_q >= 11'd30 && cnt_q <= 11'd33):
                            hdr_bad = bus.rx_data != ip_b;
                        (cnt_q == 11'd36):
                            hdr_bad = bus.rx_data != UDP_PORT[15:8];
                        (cnt_q == 11'd37):
                            hdr_bad = bus.rx_data != UDP_PORT[7:0];
                        (cnt_q == 11'd38): len_d[15:8] = bus.rx_data;
                        (cnt_q == 11'd39): begin
                            len_d[7:0] = bus.rx_data;
                            hdr_bad = (len_w < 16'd8) || (len_w > MAX_LEN);
                        end
                        default: ;
                    endcase
                    if (hdr_bad) begin
                        state_d = S_DROP;
                    end else if (cnt_q == 11'd41) begin
                        pay_len_d = 16'(len_q - 16'd8);
                        state_d   = (len_q == 16'd8) ? S_TAIL : S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (!bus.rx_dv) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (byte_v) begin
                    cnt_d       = cnt_inc;
                    crc_d       = crc_nxt;
                    pay_valid_d = 1'b1;
                    pay_data_d  = bus.rx_data;
                    pay_sof_d   = (cnt_q == 11'd42);
                    pay_eof_d   = pay_last;
                    if (pay_last) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (!bus.rx_dv) begin
                    frame_ok_d  = (crc_q == CRC_GOOD);
                    frame_err_d = (crc_q != CRC_GOOD);
                    state_d     = S_IDLE;
                end else if (byte_v) begin
                    cnt_d = cnt_inc;
                    crc_d = crc_nxt;
                end
            end
            default: state_d = S_DROP;
        endcase
    end

    // Parser and output registers; reset parks in DROP until rx_dv is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DROP;
            pre_cnt_q   <= 3'd0;
            cnt_q       <= 11'd0;
            crc_q       <= 32'hffffffff;
            uni_ok_q    <= 1'b0;
            bc_ok_q     <= 1'b0;
            len_q       <= 16'd0;
            pay_len_q   <= 16'd0;
            pay_data_q  <= 8'd0;
            pay_valid_q <= 1'b0;
            pay_sof_q   <= 1'b0;
            pay_eof_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            uni_ok_q    <= uni_ok_d;
            bc_ok_q     <= bc_ok_d;
            len_q       <= len_d;
            pay_len_q   <= pay_len_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_sof_q   <= pay_sof_d;
            pay_eof_q   <= pay_eof_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.pay_data  = pay_data_q;
    assign bus.pay_valid = pay_valid_q;
    assign bus.pay_sof   = pay_sof_q;
    assign bus.pay_eof   = pay_eof_q;
    assign bus.pay_len   = pay_len_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_udp_frame_rx.sv
// Directed bench for udp_frame_rx: two instances (broadcast accepted /
// rejected) share one receive stream; frames and FCS are built here.
module tb_udp_frame_rx;

    localparam logic [47:0] MY_MAC = 48'hd03745f66d9c;
    localparam logic [47:0] BC_MAC = 48'hffffffffffff;
    localparam logic [31:0] MY_IP  = 32'hc0a80102;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic       rx_en = 1'b0;
    logic [7:0] rx_data = 8'h00;

    udp_frame_rx_if ifa ();
    udp_frame_rx_if ifb ();

    assign ifa.rx_dv   = rx_dv;
    assign ifa.rx_en   = rx_en;
    assign ifa.rx_data = rx_data;
    assign ifb.rx_dv   = rx_dv;
    assign ifb.rx_en   = rx_en;
    assign ifb.rx_data = rx_data;

    udp_frame_rx #(.ACCEPT_BCAST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    udp_frame_rx #(.ACCEPT_BCAST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] frm[$];
    logic [7:0] pl[$];
    logic [7:0] rcv[$];
    int sof_cnt, sof_idx, eof_cnt, eof_idx, ok_cnt, err_cnt;
    int b_cnt, b_ok, b_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        return r;
    endfunction

    task automatic clear();
        rcv.delete();
        sof_cnt = 0; sof_idx = -1; eof_cnt = 0; eof_idx = -1;
        ok_cnt = 0; err_cnt = 0; b_cnt = 0; b_ok = 0; b_err = 0;
    endtask

    task automatic sample();
        if (ifa.pay_valid === 1'b1) begin
            if (ifa.pay_sof === 1'b1) begin
                sof_cnt++; sof_idx = rcv.size();
            end
            if (ifa.pay_eof === 1'b1) begin
                eof_cnt++; eof_idx = rcv.size();
            end
            rcv.push_back(ifa.pay_data);
        end
        if (ifa.frame_ok === 1'b1) ok_cnt++;
        if (ifa.frame_err === 1'b1) err_cnt++;
        if (ifb.pay_valid === 1'b1) b_cnt++;
        if (ifb.frame_ok === 1'b1) b_ok++;
        if (ifb.frame_err === 1'b1) b_err++;
    endtask

    task automatic tick(input logic dv, input logic en, input logic [7:0] d);
        @(negedge clk);
        sample();
        rx_dv = dv; rx_en = en; rx_data = d;
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] et,
                         input logic [31:0] dip, input logic [15:0] dp,
                         input int len, input bit bad);
        logic [15:0] tl;
        logic [15:0] ul;
        logic [31:0] crc;
        tl = 16'(len + 20);
        ul = 16'(len);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dmac[47 - 8*i -: 8]);
        frm.push_back(8'h02);
        for (int i = 0; i < 4; i++) frm.push_back(8'h00);
        frm.push_back(8'h01);
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(8'h45); frm.push_back(8'h00);
        frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'hc0); frm.push_back(8'ha8);
        frm.push_back(8'h01); frm.push_back(8'h01);
        for (int i = 0; i < 4; i++) frm.push_back(dip[31 - 8*i -: 8]);
        frm.push_back(8'h30); frm.push_back(8'h39);
        frm.push_back(dp[15:8]); frm.push_back(dp[7:0]);
        frm.push_back(ul[15:8]); frm.push_back(ul[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pl[i]) frm.push_back(pl[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        crc = 32'hffffffff;
        foreach (frm[i]) crc = crc_upd(crc, frm[i]);
        crc = ~crc;
        if (bad) crc = crc ^ 32'h1;
        for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
    endtask

    task automatic send(input int gap, input int npre, input int trunc,
                        input int rst_at, input int tail_idle);
        logic [7:0] st[$];
        int n;
        n = (trunc >= 0) ? trunc : frm.size();
        for (int i = 0; i < npre; i++) st.push_back(8'h55);
        st.push_back(8'hd5);
        for (int i = 0; i < n; i++) st.push_back(frm[i]);
        foreach (st[k]) begin
            for (int g = 1; g < gap; g++) tick(1'b1, 1'b0, 8'h00);
            tick(1'b1, 1'b1, st[k]);
            if (rst_at >= 0 && k == npre + 1 + rst_at) begin
                rst_n = 1'b0;
                tick(1'b1, 1'b0, 8'h00);
                tick(1'b1, 1'b0, 8'h00);
                chk("rst_mid_pay_valid", 32'(ifa.pay_valid), 32'd0);
                chk("rst_mid_pay_len", 32'(ifa.pay_len), 32'd0);
                chk("rst_mid_frame_err", 32'(ifa.frame_err), 32'd0);
                clear();
                rst_n = 1'b1;
            end
        end
        tick(1'b0, 1'b0, 8'h00);
        repeat (tail_idle) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_payload(input string tag);
        int mism;
        mism = 0;
        foreach (rcv[i])
            if (i >= pl.size() || rcv[i] !== pl[i]) mism++;
        chk(tag, mism, 0);
    endtask

    initial begin
        string s;
        clear();

        // reset state
        #12;
        chk("reset_pay_valid", 32'(ifa.pay_valid), 32'd0);
        chk("reset_frame_ok", 32'(ifa.frame_ok), 32'd0);
        chk("reset_frame_err", 32'(ifa.frame_err), 32'd0);
        chk("reset_pay_len", 32'(ifa.pay_len), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 8'h00);

        // 1: unicast, 16-byte payload, good FCS
        s = "start_of_frameve";
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 24, 1'b0);
        clear(); send(1, 7, -1, -1, 4);
        chk("t1_count", rcv.size(), 16);
        chk_payload("t1_payload");
        chk("t1_sof_cnt", sof_cnt, 1);
        chk("t1_sof_idx", sof_idx, 0);
        chk("t1_eof_cnt", eof_cnt, 1);
        chk("t1_eof_idx", eof_idx, 15);
        chk("t1_pay_len", 32'(ifa.pay_len), 16);
        chk("t1_ok", ok_cnt, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_b_ok", b_ok, 1);

        // 2: same frame, corrupted FCS
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 24, 1'b1);
        clear(); send(1, 7, -1, -1, 4);
        chk("t2_count", rcv.size(), 16);
        chk_payload("t2_payload");
        chk("t2_eof_cnt", eof_cnt, 1);
        chk("t2_ok", ok_cnt, 0);
        chk("t2_err", err_cnt, 1);

        // 3: header mismatches are dropped silently
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e22, 24, 1'b0);
        clear(); send(1, 7, -1, -1, 4);
        build(MY_MAC, 16'h0806, MY_IP, 16'h4e21, 24, 1'b0);
        send(1, 7, -1, -1, 4);
        build(MY_MAC, 16'h0800, 32'hc0a80103, 16'h4e21, 24, 1'b0);
        send(1, 7, -1, -1, 4);
        chk("t3_count", rcv.size(), 0);
        chk("t3_ok", ok_cnt, 0);
        chk("t3_err", err_cnt, 0);
        chk("t3_pay_len_kept", 32'(ifa.pay_len), 16);

        // 4: broadcast dst MAC, short preamble
        build(BC_MAC, 16'h0800, MY_IP, 16'h4e21, 24, 1'b0);
        clear(); send(1, 1, -1, -1, 4);
        chk("t4_a_count", rcv.size(), 16);
        chk("t4_a_ok", ok_cnt, 1);
        chk("t4_b_count", b_cnt, 0);
        chk("t4_b_ok", b_ok, 0);
        chk("t4_b_err", b_err, 0);

        // preamble too long
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 24, 1'b0);
        clear(); send(1, 8, -1, -1, 4);
        chk("long_pre_count", rcv.size(), 0);
        chk("long_pre_ok", ok_cnt, 0);

        // L=8: empty payload
        pl.delete();
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 8, 1'b0);
        clear(); send(1, 7, -1, -1, 4);
        chk("l8_count", rcv.size(), 0);
        chk("l8_pay_len", 32'(ifa.pay_len), 0);
        chk("l8_ok", ok_cnt, 1);

        // L above MAX_PAYLOAD+8
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 1481, 1'b0);
        clear(); send(1, 7, -1, -1, 4);
        chk("lbig_count", rcv.size(), 0);
        chk("lbig_ok", ok_cnt, 0);
        chk("lbig_err", err_cnt, 0);

        // 5: 1400-byte payload, rx_en every 2nd cycle
        pl.delete();
        for (int i = 0; i < 1400; i++) pl.push_back(8'((i * 7) + 3));
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 1408, 1'b0);
        clear(); send(2, 7, -1, -1, 4);
        chk("t5_count", rcv.size(), 1400);
        chk_payload("t5_payload");
        chk("t5_eof_idx", eof_idx, 1399);
        chk("t5_pay_len", 32'(ifa.pay_len), 1400);
        chk("t5_ok", ok_cnt, 1);
        clear(); send(2, 7, 742, -1, 4);
        chk("t5t_count", rcv.size(), 700);
        chk_payload("t5t_payload");
        chk("t5t_eof_cnt", eof_cnt, 0);
        chk("t5t_err", err_cnt, 1);
        chk("t5t_ok", ok_cnt, 0);

        // 6: reset mid-payload, then back-to-back frames
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
        build(MY_MAC, 16'h0800, MY_IP, 16'h4e21, 24, 1'b0);
        clear(); send(1, 7, -1, 45, 0);
        chk("t6_ignored_count", rcv.size(), 0);
        chk("t6_ignored_ok", ok_cnt, 0);
        chk("t6_ignored_err", err_cnt, 0);
        clear();
        send(1, 7, -1, -1, 0);
        send(1, 7, -1, -1, 4);
        chk("t6_b2b_count", rcv.size(), 32);
        chk("t6_b2b_sof", sof_cnt, 2);
        chk("t6_b2b_eof", eof_cnt, 2);
        chk("t6_b2b_ok", ok_cnt, 2);
        chk("t6_b2b_err", err_cnt, 0);
        chk("t6_pay_len", 32'(ifa.pay_len), 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
